// File: rtl/uart_cmd_wrapper.sv
// UART command wrapper: pairs received bytes into 16-bit commands (high byte first)
// with an inter-byte gap timeout, and forwards single-byte responses to the transmitter.
module uart_cmd_wrapper #(
    parameter int unsigned GAP_TIMEOUT = 50000,
    parameter int unsigned TMR_W       = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_rdy_i,
    input  logic [7:0]  rx_data_i,
    output logic        clr_rx_rdy_o,
    output logic [15:0] cmd_o,
    output logic        cmd_rdy_o,
    input  logic        clr_cmd_rdy_i,
    input  logic [7:0]  resp_i,
    input  logic        snd_resp_i,
    output logic [7:0]  tx_data_o,
    output logic        trmt_o,
    input  logic        tx_done_i,
    output logic        resp_sent_o,
    output logic        resync_err_o
);

    typedef enum logic [1:0] {RX_IDLE, RX_HIGH, RX_FULL} rx_state_e;
    typedef enum logic       {TX_IDLE, TX_BUSY}          tx_state_e;

    localparam logic [TMR_W-1:0] GAP_LAST = TMR_W'(GAP_TIMEOUT - 1);

    rx_state_e        rx_state_q, rx_state_d;
    tx_state_e        tx_state_q, tx_state_d;
    logic [7:0]       high_q, high_d;
    logic [TMR_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [15:0]      cmd_q, cmd_d;
    logic             cmd_rdy_q, cmd_rdy_d;
    logic             clr_rx_rdy_q, clr_rx_rdy_d;
    logic             resync_err_q, resync_err_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             trmt_q, trmt_d;
    logic             resp_sent_q, resp_sent_d;
    logic             consume;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q   <= RX_IDLE;
            tx_state_q   <= TX_IDLE;
            high_q       <= '0;
            gap_cnt_q    <= '0;
            cmd_q        <= '0;
            cmd_rdy_q    <= 1'b0;
            clr_rx_rdy_q <= 1'b0;
            resync_err_q <= 1'b0;
            tx_data_q    <= '0;
            trmt_q       <= 1'b0;
            resp_sent_q  <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            rx_state_q   <= rx_state_d;
            tx_state_q   <= tx_state_d;
            high_q       <= high_d;
            gap_cnt_q    <= gap_cnt_d;
            cmd_q        <= cmd_d;
            cmd_rdy_q    <= cmd_rdy_d;
            clr_rx_rdy_q <= clr_rx_rdy_d;
            resync_err_q <= resync_err_d;
            tx_data_q    <= tx_data_d;
            trmt_q       <= trmt_d;
            resp_sent_q  <= resp_sent_d;
        end
    end

    // The clr_rx_rdy_q term blocks a second take while the UART is still dropping rx_rdy.
    assign consume = rx_rdy_i && !clr_rx_rdy_q && (rx_state_q != RX_FULL);

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path infers a latch.
        rx_state_d   = rx_state_q;
        high_d       = high_q;
        gap_cnt_d    = gap_cnt_q;
        cmd_d        = cmd_q;
        cmd_rdy_d    = cmd_rdy_q;
        clr_rx_rdy_d = consume;
        resync_err_d = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (consume) begin
                    high_d     = rx_data_i;
                    gap_cnt_d  = '0;
                    rx_state_d = RX_HIGH;
                end
            end
            RX_HIGH: begin
                if (consume) begin
                    cmd_d      = {high_q, rx_data_i};
                    cmd_rdy_d  = 1'b1;
                    rx_state_d = RX_FULL;
                end else if (gap_cnt_q == GAP_LAST) begin
                    high_d       = '0;
                    resync_err_d = 1'b1;
                    rx_state_d   = RX_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + TMR_W'(1);
                end
            end
            RX_FULL: begin
                if (clr_cmd_rdy_i) begin
                    cmd_rdy_d  = 1'b0;
                    rx_state_d = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        tx_state_d  = tx_state_q;
        tx_data_d   = tx_data_q;
        trmt_d      = 1'b0;
        resp_sent_d = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                if (snd_resp_i) begin
                    tx_data_d  = resp_i;
                    trmt_d     = 1'b1;
                    tx_state_d = TX_BUSY;
                end
            end
            TX_BUSY: begin
                if (tx_done_i) begin
                    resp_sent_d = 1'b1;
                    tx_state_d  = TX_IDLE;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    assign clr_rx_rdy_o = clr_rx_rdy_q;
    assign cmd_o        = cmd_q;
    assign cmd_rdy_o    = cmd_rdy_q;
    assign resync_err_o = resync_err_q;
    assign tx_data_o    = tx_data_q;
    assign trmt_o       = trmt_q;
    assign resp_sent_o  = resp_sent_q;

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// Self-checking bench for uart_cmd_wrapper: directed scenarios followed by random
// traffic, every cycle compared against a transaction-level reference model.
module tb_uart_cmd_wrapper;

    localparam int G = 1200;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_rdy;
    logic [7:0]  rx_data;
    logic        clr_rx_rdy;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic [7:0]  resp;
    logic        snd_resp;
    logic [7:0]  tx_data;
    logic        trmt;
    logic        tx_done;
    logic        resp_sent;
    logic        resync_err;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: a pending high byte with its age, a held command, a busy transmitter.
    bit          m_pending, m_busy;
    int          m_age;
    logic [7:0]  m_hi, m_tx_data;
    logic [15:0] m_cmd;
    logic        m_cmd_rdy, m_clr, m_resync, m_trmt, m_sent;

    uart_cmd_wrapper #(.GAP_TIMEOUT(G), .TMR_W(11)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_rdy_i     (rx_rdy),
        .rx_data_i    (rx_data),
        .clr_rx_rdy_o (clr_rx_rdy),
        .cmd_o        (cmd),
        .cmd_rdy_o    (cmd_rdy),
        .clr_cmd_rdy_i(clr_cmd_rdy),
        .resp_i       (resp),
        .snd_resp_i   (snd_resp),
        .tx_data_o    (tx_data),
        .trmt_o       (trmt),
        .tx_done_i    (tx_done),
        .resp_sent_o  (resp_sent),
        .resync_err_o (resync_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        bit take;
        if (rst) begin
            m_pending = 0; m_busy = 0; m_age = 0; m_hi = '0; m_tx_data = '0;
            m_cmd = '0; m_cmd_rdy = 0; m_clr = 0; m_resync = 0; m_trmt = 0; m_sent = 0;
        end else begin
            take     = rx_rdy && !m_clr && !m_cmd_rdy;
            m_resync = 0;
            m_trmt   = 0;
            m_sent   = 0;
            if (m_cmd_rdy) begin
                if (clr_cmd_rdy) m_cmd_rdy = 0;
            end else if (m_pending) begin
                if (take) begin
                    m_cmd     = {m_hi, rx_data};
                    m_cmd_rdy = 1;
                    m_pending = 0;
                end else if (m_age == G - 1) begin
                    m_pending = 0;
                    m_resync  = 1;
                end else begin
                    m_age++;
                end
            end else if (take) begin
                m_hi      = rx_data;
                m_pending = 1;
                m_age     = 0;
            end
            m_clr = take;
            if (m_busy) begin
                if (tx_done) begin
                    m_sent = 1;
                    m_busy = 0;
                end
            end else if (snd_resp) begin
                m_tx_data = resp;
                m_trmt    = 1;
                m_busy    = 1;
            end
        end
    endtask

    // One clock: update the model at the edge, compare all outputs 1 ns later,
    // and let the modelled UART drop rx_rdy once it sees the consume pulse.
    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        chk("clr_rx_rdy", clr_rx_rdy, m_clr);
        chk("cmd",        cmd,        m_cmd);
        chk("cmd_rdy",    cmd_rdy,    m_cmd_rdy);
        chk("resync_err", resync_err, m_resync);
        chk("tx_data",    tx_data,    m_tx_data);
        chk("trmt",       trmt,       m_trmt);
        chk("resp_sent",  resp_sent,  m_sent);
        if (m_clr) rx_rdy = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic present(input logic [7:0] b);
        rx_rdy  = 1'b1;
        rx_data = b;
    endtask

    task automatic wait_consumed(input string tag);
        int n = 0;
        do begin
            step();
            n++;
        end while (!m_clr && n < 50);
        chk(tag, clr_rx_rdy, 1'b1);
    endtask

    task automatic send_byte(input logic [7:0] b, input string tag);
        present(b);
        wait_consumed(tag);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        int pulses;
        int rate;
        int len;
        rst = 1'b1; rx_rdy = 0; rx_data = 0; clr_cmd_rdy = 0;
        resp = 0; snd_resp = 0; tx_done = 0;
        step();
        rst = 1'b0;
        chk("reset_cmd", cmd, 16'h0000);
        chk("reset_cmd_rdy", cmd_rdy, 1'b0);
        chk("reset_tx_data", tx_data, 16'h0000);

        // Consume and assemble with a 1000-clock gap.
        send_byte(8'h20, "consume_hi_20");
        idle(1000);
        send_byte(8'h00, "consume_lo_00");
        chk("assemble_2000", cmd, 16'h2000);
        chk("assemble_rdy", cmd_rdy, 1'b1);
        idle(20);
        chk("cmd_rdy_held", cmd_rdy, 1'b1);

        // A byte waits while a command is held; it is taken right after the clear.
        present(8'h55);
        idle(5);
        chk("full_no_consume", clr_rx_rdy, 1'b0);
        clr_cmd_rdy = 1'b1;
        step();
        clr_cmd_rdy = 1'b0;
        chk("clear_rdy", cmd_rdy, 1'b0);
        chk("clear_no_consume", clr_rx_rdy, 1'b0);
        step();
        chk("post_clear_consume", clr_rx_rdy, 1'b1);
        chk("cmd_kept_after_clear", cmd, 16'h2000);
        idle(G + 5);

        // Gap timeout and recovery.
        send_byte(8'h41, "consume_41");
        pulses = 0;
        repeat (G + 5) begin
            step();
            pulses += int'(resync_err);
        end
        chk("resync_count", 16'(pulses), 16'd1);
        chk("timeout_no_rdy", cmd_rdy, 1'b0);
        send_byte(8'h41, "consume_41b");
        send_byte(8'h23, "consume_23");
        chk("assemble_4123", cmd, 16'h4123);
        clr_cmd_rdy = 1'b1; step(); clr_cmd_rdy = 1'b0;

        // Low byte lands on the exact timeout cycle: the byte wins.
        send_byte(8'h77, "consume_77");
        idle(G - 1);
        present(8'h88);
        step();
        chk("edge_consume", clr_rx_rdy, 1'b1);
        chk("edge_no_resync", resync_err, 1'b0);
        chk("edge_assemble", cmd, 16'h7788);
        clr_cmd_rdy = 1'b1; step(); clr_cmd_rdy = 1'b0;

        // Response transmit with an ignored request while busy.
        resp = 8'hA5; snd_resp = 1'b1; step(); snd_resp = 1'b0;
        chk("trmt_pulse", trmt, 1'b1);
        chk("tx_data_a5", tx_data, 16'h00A5);
        step();
        chk("trmt_single", trmt, 1'b0);
        resp = 8'h5A; snd_resp = 1'b1; step(); snd_resp = 1'b0;
        chk("busy_ignore_trmt", trmt, 1'b0);
        chk("busy_tx_data", tx_data, 16'h00A5);
        idle(3);
        tx_done = 1'b1; snd_resp = 1'b1; step(); tx_done = 1'b0; snd_resp = 1'b0;
        chk("resp_sent_pulse", resp_sent, 1'b1);
        chk("same_cycle_snd_ignored", trmt, 1'b0);
        step();
        chk("resp_sent_single", resp_sent, 1'b0);
        tx_done = 1'b1; step(); tx_done = 1'b0;
        chk("idle_tx_done_ignored", resp_sent, 1'b0);
        snd_resp = 1'b1; step(); snd_resp = 1'b0;
        chk("tx_data_5a", tx_data, 16'h005A);
        chk("trmt_5a", trmt, 1'b1);

        // Overlap: command assembles while the response is in flight.
        send_byte(8'h3C, "overlap_hi");
        send_byte(8'hC3, "overlap_lo");
        tx_done = 1'b1; step(); tx_done = 1'b0;
        chk("overlap_sent", resp_sent, 1'b1);
        chk("overlap_cmd", cmd, 16'h3CC3);
        clr_cmd_rdy = 1'b1; step(); clr_cmd_rdy = 1'b0;

        // Reset in HIGH and in TX_BUSY, then a late tx_done.
        send_byte(8'h99, "rst_hi");
        idle(3);
        pulse_rst();
        chk("rst_cmd", cmd, 16'h0000);
        chk("rst_rdy", cmd_rdy, 1'b0);
        resp = 8'hA5; snd_resp = 1'b1; step(); snd_resp = 1'b0;
        idle(2);
        pulse_rst();
        chk("rst_tx_data", tx_data, 16'h0000);
        tx_done = 1'b1; step(); tx_done = 1'b0;
        chk("late_tx_done", resp_sent, 1'b0);
        send_byte(8'h12, "post_rst_hi");
        send_byte(8'h34, "post_rst_lo");
        chk("assemble_1234", cmd, 16'h1234);

        // Random traffic in episodes of varying byte density.
        for (int ep = 0; ep < 20; ep++) begin
            case ($urandom % 4)
                0:       rate = 1;
                1:       rate = 4;
                2:       rate = 60;
                default: rate = 3000;
            endcase
            len = $urandom_range(50, 1500);
            for (int c = 0; c < len; c++) begin
                if (!rx_rdy && ($urandom % rate) == 0) present(8'($urandom));
                clr_cmd_rdy = (($urandom % 8) == 0);
                snd_resp    = (($urandom % 10) == 0);
                resp        = 8'($urandom);
                tx_done     = (($urandom % 6) == 0);
                rst         = (($urandom % 4000) == 0);
                step();
            end
        end
        rst = 1'b0; clr_cmd_rdy = 0; snd_resp = 0; tx_done = 0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
